// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, operands fed LSB-first.
// Latency: operands accepted at edge k give out_valid after edge k+WIDTH (WIDTH busy cycles).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one idle cycle between results).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   busy                high while bits are being shifted through the adder
//
// Build option: define SERIAL_ADDER_SUB_EN to make the sub input compute a-b.
// Without it, sub is ignored and the block always computes a+b+cin.

// Single-bit full-adder cell; the whole datapath funnels through one of these.
module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   // Counter only needs to reach WIDTH-1; it is cleared on every accept so it never wraps.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             ovf_q;
   logic [CW-1:0]    cnt_q;

   // Operand conditioning applied at accept time.
   logic [WIDTH-1:0] b_load_d;
   logic             carry_load_d;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtract as a + ~b + 1; the forced carry-in replaces cin.
   always_comb begin
      b_load_d     = sub ? ~b : b;
      carry_load_d = sub ? 1'b1 : cin;
   end
`else
   logic unused_sub;
   assign unused_sub = sub;

   always_comb begin
      b_load_d     = b;
      carry_load_d = cin;
   end
`endif

   // The adder only ever sees bit 0 of the shifting operands and the carry flop.
   logic fa_s;
   logic fa_c;

   serial_adder_fa u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // New sum bit enters at the MSB and everything moves right; after WIDTH
   // shifts the first (LSB) result bit has arrived at bit 0. Built through a
   // WIDTH+1 concatenation so WIDTH=1 needs no special case.
   logic [WIDTH:0]   sum_cat_d;
   logic [WIDTH-1:0] sum_d;
   logic             last_bit_d;

   assign sum_cat_d  = {fa_s, sum_q};
   assign sum_d      = sum_cat_d[WIDTH:1];
   assign last_bit_d = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b_load_d;
                  carry_q <= carry_load_d;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               sum_q   <= sum_d;
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= fa_c;
               cnt_q   <= cnt_q + CW'(1);
               if (last_bit_d) begin
                  // carry_q is the carry into the MSB, fa_c the carry out of it.
                  cout_q  <= fa_c;
                  ovf_q   <= carry_q ^ fa_c;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake and status depend on state alone: no path from in_valid/out_ready.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SHIFT);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // WIDTH=8 instance
   logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic       cin8, sub8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;

   // WIDTH=1 instance
   logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic       cin1, sub1, cout1, ovf1;
   logic [0:0] a1, b1, sum1;

   int n_pass  = 0;
   int n_total = 0;

   // Expected {sum, cout, ovf}
   logic [9:0] q8[$];
   logic [2:0] q1[$];

   // WIDTH=1 sweep, index = {b,a,cin}; entries {sum, cout, ovf}, ovf = cin ^ cout.
   logic [2:0] exp1 [8] = '{3'b000, 3'b101, 3'b100, 3'b010,
                            3'b100, 3'b010, 3'b011, 3'b110};

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   // Monitors: pop and compare on every result handshake.
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
         if (q8.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result8: actual 0x%0h required no result", {sum8, cout8, ovf8});
         end else begin
            check("result8", {sum8, cout8, ovf8}, q8.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result1: actual 0x%0h required no result", {sum1, cout1, ovf1});
         end else begin
            check("result1", {sum1, cout1, ovf1}, q1.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic su,
                         input logic [9:0] exp, input bit track);
      int n = 0;
      while (in_ready8 !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("in_ready8_wait", in_ready8, 1'b1);
      a8 = a; b8 = b; cin8 = ci; sub8 = su;
      in_valid8 = 1'b1;
      if (track) q8.push_back(exp);
      step();
      in_valid8 = 1'b0;
   endtask

   task automatic wait_out8(input string name);
      int n = 0;
      while (out_valid8 !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check(name, out_valid8, 1'b1);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic su,
                       input logic [9:0] exp);
      issue8(a, b, ci, su, exp, 1'b1);
      wait_out8("run8_valid");
      step();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: actual no finish required finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen;
      rst = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready",  in_ready8,  1'b1);
      check("rst_out_valid", out_valid8, 1'b0);
      check("rst_busy",      busy8,      1'b0);
      check("rst_sum",       sum8,       8'h00);
      check("rst_cout",      cout8,      1'b0);
      check("rst_ovf",       ovf8,       1'b0);
      check("rst_in_ready1", in_ready1,  1'b1);

      // Reset during the third shift aborts the operation
      issue8(8'hAA, 8'h55, 1'b0, 1'b0, '0, 1'b0);
      step();
      step();
      check("mid_busy", busy8, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_in_ready", in_ready8, 1'b1);
      check("abort_busy",     busy8,     1'b0);
      check("abort_sum",      sum8,      8'h00);
      seen = 1'b0;
      repeat (12) begin
         if (out_valid8 === 1'b1) seen = 1'b1;
         step();
      end
      check("abort_no_valid", seen, 1'b0);

      // 0x0F + 0x01: exactly 8 busy cycles
      issue8(8'h0F, 8'h01, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0}, 1'b1);
      n = 0;
      while (busy8 === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check("busy_cycles", n, 8);
      check("valid_after_busy", out_valid8, 1'b1);
      step();
      check("idle_after_result", in_ready8, 1'b1);

      // Carry-out and signed overflow
      run8(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
      run8(8'h7F, 8'h00, 1'b1, 1'b0, {8'h80, 1'b0, 1'b1});

      // Subtract option
`ifdef SERIAL_ADDER_SUB_EN
      run8(8'h05, 8'h07, 1'b0, 1'b1, {8'hFE, 1'b0, 1'b0});
      run8(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
`else
      run8(8'h05, 8'h07, 1'b0, 1'b1, {8'h0C, 1'b0, 1'b0});
      run8(8'h80, 8'h01, 1'b0, 1'b1, {8'h81, 1'b0, 1'b0});
`endif

      // Backpressure: hold result, refuse new operands
      out_ready8 = 1'b0;
      issue8(8'h60, 8'h50, 1'b0, 1'b0, {8'hB0, 1'b0, 1'b1}, 1'b1);
      wait_out8("bp_valid");
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0;
      in_valid8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", in_ready8, 1'b0);
         check("bp_hold", {sum8, cout8, ovf8}, {8'hB0, 1'b0, 1'b1});
         step();
      end
      check("bp_still_valid", out_valid8, 1'b1);
      out_ready8 = 1'b1;
      q8.push_back({8'h33, 1'b0, 1'b0});
      step();
      check("bp_release_idle",  in_ready8,  1'b1);
      check("bp_release_valid", out_valid8, 1'b0);
      check("bp_sum_held",      sum8,       8'hB0);
      step();
      in_valid8 = 1'b0;
      check("bp_accept", busy8, 1'b1);
      wait_out8("bp_next_valid");
      step();

      // WIDTH=1 exhaustive sweep, one busy cycle each
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = v[2:0];
         a1 = vv[1];
         b1 = vv[2];
         cin1 = vv[0];
         in_valid1 = 1'b1;
         q1.push_back(exp1[v]);
         step();
         in_valid1 = 1'b0;
         check("w1_busy", busy1, 1'b1);
         step();
         check("w1_valid", out_valid1, 1'b1);
         step();
      end

      step();
      check("q8_drained", q8.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
